elem_credit_drain: RTL and testbench
====================================

// Module: elem_credit_drain
// PURPOSE
//  Consumer end of the element rate-match queue interface: drains up to NW elements/cycle
//  (val/val_cnt/rdy/rdy_cnt handshake) and forwards them through one register stage.
//  The downstream sink uses credit flow control (1 credit = 1 element slot).
//  Sits between the element queue output and the issue/execute stage.
// PARAMETERS
//  ET        logic[31:0]  element type
//  NW        2            max elements accepted/forwarded per cycle (power of 2, >=1)
//  CRD_MAX   8            downstream slots = reset credit value (>= NW)
//  NWCW      localparam   $clog2(NW+1), count width 0..NW
//  CRDW      localparam   $clog2(CRD_MAX+1), credit width 0..CRD_MAX
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous reset, active-high
//  init         in   1        synchronous re-init; same effect as rst
//  in_val       in   1        queue has >=1 element
//  in_val_cnt   in   NWCW     elements presented, positions 0..in_val_cnt-1
//  in_rdy       out  1        drain accepts this cycle
//  in_rdy_cnt   out  NWCW     elements taken, positions 0..in_rdy_cnt-1
//  in_data      in   ET[0:NW-1]  unpacked element array; [0] is the oldest
//  out_val      out  1        registered beat valid
//  out_cnt      out  NWCW     elements in beat, positions 0..out_cnt-1
//  out_data     out  ET[0:NW-1]  registered elements
//  crd_ret      in   1        sink returns credits
//  crd_ret_cnt  in   CRDW     credits returned (qualified by crd_ret)
//  credits      out  CRDW     current credit count
//  err_ovf      out  1        sticky: credit return exceeded CRD_MAX
// BEHAVIOUR
//  - Reset/init: credits=CRD_MAX, out_val=0, out_cnt=0, err_ovf=0, out_data don't-care.
//    crd_ret is ignored in the cycle rst or init is high. In-flight beat is dropped.
//  - in_rdy (comb) = !rst & !init & (credits != 0).
//  - in_rdy_cnt (comb) = min(in_val_cnt, credits, NW). Never exceeds in_val_cnt.
//    The queue advances its read pointer by in_rdy_cnt whenever in_val & in_rdy.
//  - take = (in_val & in_rdy) ? in_rdy_cnt : 0. No comb path from crd_ret to in_rdy*.
//  - Output: 1-cycle latency. out_val <= (take != 0); out_cnt <= take.
//    out_data[i] <= in_data[i] for i < take; slots >= take hold their value.
//    Order is preserved. No output backpressure; credits guarantee sink space.
//  - Credits (CRDW+1 bit arithmetic):
//    ncred = credits - take + (crd_ret ? crd_ret_cnt : 0).
//    take and return in the same cycle are both applied.
//    Returned credits are usable the next cycle.
//  - Overflow: if ncred > CRD_MAX, credits <= CRD_MAX and err_ovf <= 1.
//    err_ovf is cleared only by rst/init.
//  - Underflow is impossible by construction (take <= credits). An SVA asserts it.
//  - credits=0: in_rdy=0 and in_rdy_cnt=0 until a return lands.
//  - in_val=0 or in_val_cnt=0: take=0, out_val=0 next cycle, credits change only by returns.
// STRUCTURE
//  - Package elem_pkg: elem_t (= logic[31:0]); functions min_u(a,b) and cnt_w(n)=$clog2(n+1).
//    Shared with the element queue.
//  - Sub-module elem_crd_cnt: credit counter holding take/return/saturate/err_ovf logic.
//    Parameters CRD_MAX and NW.
//  - Top level: ready/count comb logic plus the output register stage.
// TESTING
//  1. Reset with NW=2, CRD_MAX=8; hold in_val=1, in_val_cnt=2, no returns ->
//     4 beats of out_cnt=2, credits 8->6->4->2->0. Then in_rdy=0 and out_val=0 next cycle.
//  2. credits=1, in_val_cnt=2 -> in_rdy_cnt=1; next cycle out_cnt=1 with out_data[0]=in_data[0].
//  3. credits=0, crd_ret=1 with crd_ret_cnt=3 -> in_rdy=0 that cycle;
//     next cycle credits=3 and in_rdy_cnt=2.
//  4. credits=4, take=2 and return=2 in the same cycle -> credits stay 4, out_cnt=2 next cycle.
//  5. credits=7, return=3 -> credits=8 (saturated), err_ovf=1 and sticky until init.
//  6. rst pulse mid-stream with out_val=1 and credits=2 ->
//     next cycle out_val=0, credits=8, err_ovf=0; crd_ret during the rst cycle is ignored.

Source files
------------

// File: rtl/elem_pkg.sv
// Element types and small helpers shared by the element queue and its consumers.
package elem_pkg;

   typedef logic [31:0] elem_t;

   // Unsigned minimum of two counts.
   function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

   // Bits needed to hold a count in the range 0..n.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/elem_crd_cnt.sv
// Downstream credit counter: subtracts elements taken and adds returned credits,
// saturating at CRD_MAX. Any return that would exceed CRD_MAX sets a sticky error flag.
module elem_crd_cnt
   import elem_pkg::*;
#(
   parameter  int CRD_MAX = 8,
   parameter  int NW      = 2,
   localparam int CRDW    = cnt_w(CRD_MAX),
   localparam int NWCW    = cnt_w(NW)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            init,
   input  logic [NWCW-1:0] take,
   input  logic            crd_ret,
   input  logic [CRDW-1:0] crd_ret_cnt,
   output logic [CRDW-1:0] credits,
   output logic            err_ovf
);

   logic [CRDW-1:0] credits_q, credits_d;
   logic            err_ovf_q, err_ovf_d;
   logic [CRDW:0]   ncred;
   logic [CRDW:0]   take_x;
   logic [CRDW:0]   ret_x;

   // Next credit value: one extra bit so an over-return is visible before saturation.
   always_comb begin
      take_x    = {{(CRDW + 1 - NWCW){1'b0}}, take};
      ret_x     = crd_ret ? {1'b0, crd_ret_cnt} : '0;
      ncred     = {1'b0, credits_q} - take_x + ret_x;
      credits_d = ncred[CRDW-1:0];
      err_ovf_d = err_ovf_q;
      if (ncred > (CRDW + 1)'(CRD_MAX)) begin
         credits_d = CRDW'(CRD_MAX);
         err_ovf_d = 1'b1;
      end
   end

   // Credit and error state; rst and init both restore a full credit pool and drop any return.
   always_ff @(posedge clk) begin
      if (rst || init) begin
         credits_q <= CRDW'(CRD_MAX);
         err_ovf_q <= 1'b0;
      end else begin
         credits_q <= credits_d;
         err_ovf_q <= err_ovf_d;
      end
   end

   assign credits = credits_q;
   assign err_ovf = err_ovf_q;

`ifndef SYNTHESIS
   // The ready count is bounded by credits, so taking more than we hold is a design bug.
   a_no_underflow : assert property (@(posedge clk) disable iff (rst || init)
      take_x <= {1'b0, credits_q});
`endif

endmodule

// File: rtl/elem_credit_drain.sv
// Consumer end of the element queue: accepts up to NW elements per cycle, bounded by
// downstream credits, and forwards them through a single register stage in order.
module elem_credit_drain
   import elem_pkg::*;
#(
   parameter  type ET      = elem_t,
   parameter  int  NW      = 2,
   parameter  int  CRD_MAX = 8,
   localparam int  NWCW    = cnt_w(NW),
   localparam int  CRDW    = cnt_w(CRD_MAX)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            init,
   input  logic            in_val,
   input  logic [NWCW-1:0] in_val_cnt,
   output logic            in_rdy,
   output logic [NWCW-1:0] in_rdy_cnt,
   input  ET               in_data [0:NW-1],
   output logic            out_val,
   output logic [NWCW-1:0] out_cnt,
   output ET               out_data [0:NW-1],
   input  logic            crd_ret,
   input  logic [CRDW-1:0] crd_ret_cnt,
   output logic [CRDW-1:0] credits,
   output logic            err_ovf
);

   logic [NWCW-1:0] take;
   logic            out_val_q, out_val_d;
   logic [NWCW-1:0] out_cnt_q, out_cnt_d;
   ET               out_data_q [0:NW-1];
   ET               out_data_d [0:NW-1];

   // Ready side depends only on registered credits, never on this cycle's return.
   always_comb begin
      in_rdy     = !rst && !init && (credits != '0);
      in_rdy_cnt = NWCW'(min_u(min_u(32'(in_val_cnt), 32'(credits)), NW));
      take       = (in_val && in_rdy) ? in_rdy_cnt : '0;
   end

   elem_crd_cnt #(
      .CRD_MAX (CRD_MAX),
      .NW      (NW)
   ) u_crd (
      .clk         (clk),
      .rst         (rst),
      .init        (init),
      .take        (take),
      .crd_ret     (crd_ret),
      .crd_ret_cnt (crd_ret_cnt),
      .credits     (credits),
      .err_ovf     (err_ovf)
   );

   // Next beat: accepted lanes load new elements, unused lanes keep their old contents.
   always_comb begin
      out_val_d = (take != '0);
      out_cnt_d = take;
      for (int i = 0; i < NW; i++) begin
         out_data_d[i] = (i < int'(take)) ? in_data[i] : out_data_q[i];
      end
   end

   // Beat valid/count; reset or init drops whatever beat was in flight.
   always_ff @(posedge clk) begin
      if (rst || init) begin
         out_val_q <= 1'b0;
         out_cnt_q <= '0;
      end else begin
         out_val_q <= out_val_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   // Payload register carries no reset; it is only meaningful while out_val is high.
   always_ff @(posedge clk) begin
      out_data_q <= out_data_d;
   end

   assign out_val  = out_val_q;
   assign out_cnt  = out_cnt_q;
   assign out_data = out_data_q;

endmodule

// File: tb/tb_elem_credit_drain.sv
// Bench for elem_credit_drain: a credit/queue reference model predicts beats into a
// scoreboard; a monitor pops and compares whenever the drain presents a beat.
module tb_elem_credit_drain;

   localparam int NW      = 2;
   localparam int CRD_MAX = 8;
   localparam int NWCW    = $clog2(NW + 1);
   localparam int CRDW    = $clog2(CRD_MAX + 1);

   logic            clk = 1'b0;
   logic            rst, init, in_val, in_rdy, out_val, crd_ret, err_ovf;
   logic [NWCW-1:0] in_val_cnt, in_rdy_cnt, out_cnt;
   logic [CRDW-1:0] crd_ret_cnt, credits;
   logic [31:0]     in_data  [0:NW-1];
   logic [31:0]     out_data [0:NW-1];

   int errors = 0;
   int checks = 0;

   // model state
   int m_cred;
   bit m_ovf;
   int q_cnt[$];
   logic [NW-1:0][31:0] q_dat[$];

   elem_credit_drain #(.NW(NW), .CRD_MAX(CRD_MAX)) dut (
      .clk(clk), .rst(rst), .init(init),
      .in_val(in_val), .in_val_cnt(in_val_cnt), .in_rdy(in_rdy), .in_rdy_cnt(in_rdy_cnt),
      .in_data(in_data), .out_val(out_val), .out_cnt(out_cnt), .out_data(out_data),
      .crd_ret(crd_ret), .crd_ret_cnt(crd_ret_cnt), .credits(credits), .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus, called just after a rising edge.
   task automatic drive(input bit v, input int vc, input bit r, input int rc,
                        input bit rs, input bit ini);
      int exp_cnt, take, n;
      bit exp_rdy;
      logic [NW-1:0][31:0] d;
      in_val      = v;
      in_val_cnt  = NWCW'(vc);
      crd_ret     = r;
      crd_ret_cnt = CRDW'(rc);
      rst         = rs;
      init        = ini;
      for (int i = 0; i < NW; i++) begin
         d[i]       = $urandom;
         in_data[i] = d[i];
      end
      #1;
      exp_rdy = !rs && !ini && (m_cred > 0);
      exp_cnt = vc;
      if (m_cred < exp_cnt) exp_cnt = m_cred;
      if (NW < exp_cnt) exp_cnt = NW;
      chk("credits", int'(credits), m_cred);
      chk("err_ovf", int'(err_ovf), int'(m_ovf));
      chk("in_rdy", int'(in_rdy), int'(exp_rdy));
      chk("in_rdy_cnt", int'(in_rdy_cnt), exp_cnt);
      take = (v && exp_rdy) ? exp_cnt : 0;
      if (take > 0) begin
         q_cnt.push_back(take);
         q_dat.push_back(d);
      end
      if (rs || ini) begin
         m_cred = CRD_MAX;
         m_ovf  = 1'b0;
      end else begin
         n = m_cred - take + (r ? rc : 0);
         if (n > CRD_MAX) begin
            m_cred = CRD_MAX;
            m_ovf  = 1'b1;
         end else begin
            m_cred = n;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every presented beat must match the oldest predicted beat.
   initial begin
      forever begin
         @(negedge clk);
         if (out_val === 1'b1) begin
            if (q_cnt.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL beat_unexpected: out_cnt=%0d with no beat predicted at %0t",
                        out_cnt, $time);
            end else begin
               int c;
               logic [NW-1:0][31:0] d;
               c = q_cnt.pop_front();
               d = q_dat.pop_front();
               chk("out_cnt", int'(out_cnt), c);
               for (int i = 0; i < c; i++) begin
                  checks++;
                  if (out_data[i] !== d[i]) begin
                     errors++;
                     $display("FAIL out_data[%0d]: got %h expected %h at %0t",
                              i, out_data[i], d[i], $time);
                  end
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1; init = 1'b0; in_val = 1'b0; in_val_cnt = '0;
      crd_ret = 1'b0; crd_ret_cnt = '0;
      for (int i = 0; i < NW; i++) in_data[i] = '0;
      @(posedge clk);
      #1;
      m_cred = CRD_MAX;
      m_ovf  = 1'b0;
      // reset, with a return that must be ignored
      drive(0, 0, 1, 3, 1, 0);
      drive(0, 0, 0, 0, 0, 0);
      // drain the full pool: 8->6->4->2->0, then stall
      repeat (4) drive(1, 2, 0, 0, 0, 0);
      drive(1, 2, 0, 0, 0, 0);
      // return while empty: no ready this cycle, usable next cycle
      drive(1, 2, 1, 3, 0, 0);
      drive(1, 2, 0, 0, 0, 0);
      // one credit left: partial take of 1
      drive(1, 2, 0, 0, 0, 0);
      drive(0, 0, 1, 4, 0, 0);
      // take 2 and return 2 together
      drive(1, 2, 1, 2, 0, 0);
      drive(0, 0, 1, 3, 0, 0);
      // 7 + 3 saturates at 8 and latches the error
      drive(0, 0, 1, 3, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      // rst mid-stream with a beat in flight and a return during rst
      repeat (3) drive(1, 2, 0, 0, 0, 0);
      drive(1, 2, 1, 5, 1, 0);
      drive(0, 0, 0, 0, 0, 0);
      // overflow again, then init clears it
      drive(1, 1, 1, 4, 0, 0);
      drive(1, 2, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0);
      // random traffic
      for (int k = 0; k < 600; k++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, NW),
               $urandom_range(0, 2) == 0, $urandom_range(0, 4),
               $urandom_range(0, 79) == 0, $urandom_range(0, 79) == 0);
      end
      repeat (3) drive(0, 0, 0, 0, 0, 0);
      chk("scoreboard_empty", q_cnt.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
